// File: rtl/window_stream.sv
// -----------------------------------------------------------------------------
// window_stream
//   Sample-serial window unit that sits between sample capture and the FFT.
//   Each accepted sample of an N-point frame is multiplied by a Hamming or
//   Hann coefficient. The product is rounded, saturated and emitted on a
//   valid/ready stream together with its index within the frame.
//
//   Optional feature macro: WINDOW_COEF_WR_EN
//     When defined, the block gains a writable user coefficient table that
//     win_sel = 2 selects. The table resets to the Hamming values.
//     When undefined, win_sel = 2 behaves as Hamming.
//
// Ports
//   clk, rst        clock; synchronous active-high reset
//   win_sel   [1:0] 0/3 Hamming, 1 Hann, 2 user table (Hamming without macro)
//   s_valid/s_ready/s_data/s_last      input sample stream (signed DW bits)
//   m_valid/m_ready/m_data/m_index/m_last  output windowed sample stream
//   frame_cnt [FCW] number of delivered frames (m_last handshakes), wraps
//   frame_err       sticky flag: s_last arrived before index N-1
//   coef_we/coef_addr/coef_wdata  user table write port (macro builds only)
// -----------------------------------------------------------------------------
module window_stream #(
  parameter int N   = 128,
  parameter int DW  = 8,
  parameter int CW  = 8,
  parameter int FCW = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [1:0]             win_sel,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic signed [DW-1:0]   s_data,
  input  logic                   s_last,
`ifdef WINDOW_COEF_WR_EN
  input  logic                   coef_we,
  input  logic [$clog2(N)-1:0]   coef_addr,
  input  logic [CW-1:0]          coef_wdata,
`endif
  output logic                   m_valid,
  input  logic                   m_ready,
  output logic signed [DW-1:0]   m_data,
  output logic [$clog2(N)-1:0]   m_index,
  output logic                   m_last,
  output logic [FCW-1:0]         frame_cnt,
  output logic                   frame_err
);

  localparam int  IW = $clog2(N);
  localparam int  PW = DW + CW + 1;
  localparam real PI = 3.14159265358979323846;

  // Builds a whole window table at elaboration time.
  // Coefficients are sampled at the half-sample points (n + 0.5) so the
  // table is symmetric. Each value is rounded to CW fraction bits and
  // clamped so that a window value of 1.0 still fits in CW unsigned bits.
  function automatic logic [N*CW-1:0] build_table(input bit hann);
    logic [N*CW-1:0] tab;
    real             w;
    int              c;
    tab = '0;
    for (int n = 0; n < N; n++) begin
      if (hann)
        w = 0.5 - 0.5 * $cos(2.0 * PI * (real'(n) + 0.5) / real'(N));
      else
        w = 0.54 - 0.46 * $cos(2.0 * PI * (real'(n) + 0.5) / real'(N));
      c = $rtoi(w * real'(1 << CW) + 0.5);
      if (c > (1 << CW) - 1) c = (1 << CW) - 1;
      tab[n*CW +: CW] = c[CW-1:0];
    end
    return tab;
  endfunction

  localparam logic [N*CW-1:0] HAMMING_TAB = build_table(1'b0);
  localparam logic [N*CW-1:0] HANN_TAB    = build_table(1'b1);

  localparam logic signed [PW-1:0] RND  = PW'(2 ** (CW - 1));
  localparam logic signed [PW-1:0] MAXV = PW'((2 ** (DW - 1)) - 1);
  localparam logic signed [PW-1:0] MINV = -PW'(2 ** (DW - 1));

  logic                 adv;
  logic                 accept;
  logic                 idx_wrap;
  logic [IW-1:0]        in_idx;
  logic [1:0]           frame_sel;
  logic [1:0]           cur_sel;
  logic [CW-1:0]        lookup_coef;

  logic                 s1_valid;
  logic signed [DW-1:0] s1_data;
  logic [CW-1:0]        s1_coef;
  logic [IW-1:0]        s1_index;
  logic                 s1_last;

  logic signed [PW-1:0] prod;
  logic signed [PW-1:0] rounded;
  logic signed [PW-1:0] shifted;
  logic signed [DW-1:0] sat_data;

  // The whole pipe moves together.
  // Nothing advances while the output register holds an unaccepted sample.
  assign adv      = !m_valid || m_ready;
  assign s_ready  = adv;
  assign accept   = s_valid && s_ready;
  assign idx_wrap = s_last || (in_idx == IW'(N - 1));

`ifdef WINDOW_COEF_WR_EN
  logic [CW-1:0] user_tab [N];

  // The user coefficient table starts out as a copy of Hamming.
  // Writes land on the clock edge. A lookup of the same address in that
  // cycle therefore still sees the previous contents.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < N; i++) user_tab[i] <= HAMMING_TAB[i*CW +: CW];
    end else if (coef_we) begin
      user_tab[coef_addr] <= coef_wdata;
    end
  end
`endif

  // Coefficient lookup for the sample being accepted.
  // At index 0 the live win_sel is used directly because that is the moment
  // it gets latched for the rest of the frame.
  always_comb begin
    cur_sel     = (in_idx == '0) ? win_sel : frame_sel;
    lookup_coef = HAMMING_TAB[in_idx*CW +: CW];
    case (cur_sel)
      2'd1:    lookup_coef = HANN_TAB[in_idx*CW +: CW];
`ifdef WINDOW_COEF_WR_EN
      2'd2:    lookup_coef = user_tab[in_idx];
`endif
      default: ;
    endcase
  end

  // Multiply by the unsigned coefficient, round half-up, then saturate.
  // The coefficient is zero-extended so that a value of 255 is not read as
  // negative. The arithmetic shift gives floor division for negative
  // products.
  always_comb begin
    prod     = PW'(s1_data) * PW'($signed({1'b0, s1_coef}));
    rounded  = prod + RND;
    shifted  = rounded >>> CW;
    sat_data = shifted[DW-1:0];
    if (shifted > MAXV)      sat_data = MAXV[DW-1:0];
    else if (shifted < MINV) sat_data = MINV[DW-1:0];
  end

  // Input side: frame index tracking, window latch and the sticky error.
  // An early s_last closes the frame at the current index. So does reaching
  // N-1 with no s_last at all.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_idx    <= '0;
      frame_sel <= 2'd0;
      frame_err <= 1'b0;
    end else if (accept) begin
      in_idx <= idx_wrap ? '0 : in_idx + IW'(1);
      if (in_idx == '0) frame_sel <= win_sel;
      if (s_last && (in_idx != IW'(N - 1))) frame_err <= 1'b1;
    end
  end

  // Stage 1 holds the sample, its index, its coefficient and its end-of-frame
  // flag. Stage 2 is the output register fed by the rounding logic.
  // Both stages freeze together when adv is low. This is why a stall
  // releases with no bubble.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_valid <= 1'b0;
      s1_data  <= '0;
      s1_coef  <= '0;
      s1_index <= '0;
      s1_last  <= 1'b0;
      m_valid  <= 1'b0;
      m_data   <= '0;
      m_index  <= '0;
      m_last   <= 1'b0;
    end else if (adv) begin
      s1_valid <= s_valid;
      if (s_valid) begin
        s1_data  <= s_data;
        s1_coef  <= lookup_coef;
        s1_index <= in_idx;
        s1_last  <= idx_wrap;
      end
      m_valid <= s1_valid;
      if (s1_valid) begin
        m_data  <= sat_data;
        m_index <= s1_index;
        m_last  <= s1_last;
      end
    end
  end

  // Counts frames as they leave the block, not as they enter it.
  always_ff @(posedge clk) begin
    if (rst)                            frame_cnt <= '0;
    else if (m_valid && m_ready && m_last) frame_cnt <= frame_cnt + FCW'(1);
  end

endmodule

// File: tb/tb_window_stream.sv
module tb_window_stream;

  localparam int  N   = 128;
  localparam int  DW  = 8;
  localparam int  CW  = 8;
  localparam int  FCW = 16;
  localparam int  IW  = $clog2(N);
  localparam real PI  = 3.14159265358979323846;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [1:0]           win_sel;
  logic                 s_valid, s_ready, s_last;
  logic signed [DW-1:0] s_data;
  logic                 m_valid, m_ready, m_last;
  logic signed [DW-1:0] m_data;
  logic [IW-1:0]        m_index;
  logic [FCW-1:0]       frame_cnt;
  logic                 frame_err;
`ifdef WINDOW_COEF_WR_EN
  logic                 coef_we;
  logic [IW-1:0]        coef_addr;
  logic [CW-1:0]        coef_wdata;
  bit                   rand_writes;
`endif

  always #5 clk = ~clk;

  window_stream #(.N(N), .DW(DW), .CW(CW), .FCW(FCW)) dut (
    .clk       (clk),
    .rst       (rst),
    .win_sel   (win_sel),
    .s_valid   (s_valid),
    .s_ready   (s_ready),
    .s_data    (s_data),
    .s_last    (s_last),
`ifdef WINDOW_COEF_WR_EN
    .coef_we   (coef_we),
    .coef_addr (coef_addr),
    .coef_wdata(coef_wdata),
`endif
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_index   (m_index),
    .m_last    (m_last),
    .frame_cnt (frame_cnt),
    .frame_err (frame_err)
  );

  typedef struct {
    int data;
    int index;
    bit last;
  } out_t;

  out_t exp_q[$];
  out_t obs_q[$];
  int   errors = 0;
  int   checks = 0;
  int   model_idx;
  int   model_sel;
  bit   model_err;
  int   model_frames;
  int   user_tab[N];

  // Reference window value written straight from the cosine formula.
  function automatic int coef_of(input int sel, input int n);
    real w;
    int  c;
`ifdef WINDOW_COEF_WR_EN
    if (sel == 2) return user_tab[n];
`endif
    if (sel == 1) w = 0.5 - 0.5 * $cos(2.0 * PI * (n + 0.5) / N);
    else          w = 0.54 - 0.46 * $cos(2.0 * PI * (n + 0.5) / N);
    c = $rtoi(w * 256.0 + 0.5);
    if (c > 255) c = 255;
    return c;
  endfunction

  // Windowed sample: product, round half-up with a floor shift, then clamp.
  function automatic int windowed(input int d, input int c);
    int r;
    r = (d * c + 128) >>> 8;
    if (r > 127)  r = 127;
    if (r < -128) r = -128;
    return r;
  endfunction

  // One clock of stimulus, entered and left at a falling edge.
  // Handshakes are judged #1 after the inputs change, which is ahead of the
  // rising edge that commits them. Accepted samples feed the reference model
  // and delivered samples go into the observed queue.
  task automatic applyStimulus(input bit v, input int d, input bit l, input bit mr, output bit acc);
    out_t o;
    s_valid = v;
    s_data  = DW'(d);
    s_last  = l;
    m_ready = mr;
`ifdef WINDOW_COEF_WR_EN
    if (rand_writes) begin
      coef_we    = ($urandom_range(0, 3) == 0);
      coef_addr  = IW'($urandom_range(0, N - 1));
      coef_wdata = CW'($urandom_range(0, 255));
    end
`endif
    #1;
    acc = s_valid && s_ready;
    if (m_valid && m_ready) begin
      o.data  = int'(m_data);
      o.index = int'(m_index);
      o.last  = m_last;
      obs_q.push_back(o);
    end
    if (acc) begin
      if (model_idx == 0) model_sel = int'(win_sel);
      o.data  = windowed(d, coef_of(model_sel, model_idx));
      o.index = model_idx;
      o.last  = l || (model_idx == N - 1);
      if (l && model_idx != N - 1) model_err = 1'b1;
      if (o.last) model_frames++;
      model_idx = o.last ? 0 : model_idx + 1;
      exp_q.push_back(o);
    end
`ifdef WINDOW_COEF_WR_EN
    if (coef_we) user_tab[coef_addr] = int'(coef_wdata);
`endif
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst     = 1'b1;
    s_valid = 1'b0;
    s_last  = 1'b0;
    s_data  = '0;
    m_ready = 1'b1;
    win_sel = 2'd0;
`ifdef WINDOW_COEF_WR_EN
    coef_we     = 1'b0;
    coef_addr   = '0;
    coef_wdata  = '0;
    rand_writes = 1'b0;
    for (int i = 0; i < N; i++) user_tab[i] = coef_of(0, i);
`endif
    repeat (2) @(negedge clk);
    rst = 1'b0;
    model_idx    = 0;
    model_sel    = 0;
    model_err    = 1'b0;
    model_frames = 0;
    exp_q.delete();
    obs_q.delete();
  endtask

  task automatic flush();
    bit acc;
    repeat (4) applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
  endtask

  // Feeds len samples. Sample force_idx gets force_val. win_sel takes sel
  // on the first sample and is scrambled afterwards, since the latched
  // selection must ride out those changes.
  task automatic feed_frame(input int sel, input int force_idx, input int force_val,
                            input int len, input bit with_last, input bit rand_ready);
    int d;
    int tries;
    bit acc;
    bit mr;
    for (int k = 0; k < len; k++) begin
      d = int'($urandom_range(0, 255)) - 128;
      if (k == force_idx) d = force_val;
      win_sel = (k == 0) ? 2'(sel) : 2'($urandom_range(0, 3));
      tries = 0;
      do begin
        mr = rand_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
        applyStimulus(1'b1, d, with_last && (k == len - 1), mr, acc);
        tries++;
      end while (!acc && tries < 50);
      if (!acc) begin
        checks++; errors++;
        $display("[TB] FAIL accept_timeout: sample %0d not accepted, wanted accept within 50 cycles", k);
        return;
      end
    end
  endtask

  task automatic test_reset();
    do_reset();
    checks += 7;
    if (m_valid !== 1'b0)   begin errors++; $display("[TB] FAIL reset_m_valid: got %0b, expected 0", m_valid); end
    if (m_data !== '0)      begin errors++; $display("[TB] FAIL reset_m_data: got %0d, expected 0", m_data); end
    if (m_index !== '0)     begin errors++; $display("[TB] FAIL reset_m_index: got %0d, expected 0", m_index); end
    if (m_last !== 1'b0)    begin errors++; $display("[TB] FAIL reset_m_last: got %0b, expected 0", m_last); end
    if (frame_cnt !== '0)   begin errors++; $display("[TB] FAIL reset_frame_cnt: got %0d, expected 0", frame_cnt); end
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_frame_err: got %0b, expected 0", frame_err); end
    if (s_ready !== 1'b1)   begin errors++; $display("[TB] FAIL reset_s_ready: got %0b, expected 1", s_ready); end
  endtask

  task automatic test_latency();
    bit acc;
    do_reset();
    win_sel = 2'd0;
    applyStimulus(1'b1, 100, 1'b0, 1'b1, acc);
    checks += 2;
    if (acc !== 1'b1)     begin errors++; $display("[TB] FAIL lat_accept: got %0b, expected 1", acc); end
    if (m_valid !== 1'b0) begin errors++; $display("[TB] FAIL lat_early_valid: got %0b, expected 0", m_valid); end
    applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    checks += 4;
    if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL lat_valid: got %0b, expected 1", m_valid); end
    if (m_data !== 8'sd8) begin errors++; $display("[TB] FAIL lat_data: got %0d, expected 8", m_data); end
    if (m_index !== '0)   begin errors++; $display("[TB] FAIL lat_index: got %0d, expected 0", m_index); end
    if (m_last !== 1'b0)  begin errors++; $display("[TB] FAIL lat_last: got %0b, expected 0", m_last); end
    flush();
  endtask

  task automatic test_hamming_peak();
    int want[2];
    int hits;
    want[0] = 127;
    want[1] = -127;
    hits = 0;
    do_reset();
    feed_frame(0, 63, 127, N, 1'b1, 1'b0);
    feed_frame(0, 63, -128, N, 1'b1, 1'b0);
    flush();
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].index == 63 && hits < 2) begin
        checks++;
        if (obs_q[i].data !== want[hits]) begin
          errors++;
          $display("[TB] FAIL peak_n63_%0d: got %0d, expected %0d", hits, obs_q[i].data, want[hits]);
        end
        hits++;
      end
    end
    checks++;
    if (hits !== 2) begin errors++; $display("[TB] FAIL peak_hits: got %0d, expected 2", hits); end
  endtask

  task automatic test_hann_frame();
    int lasts;
    do_reset();
    feed_frame(1, 0, 127, N, 1'b1, 1'b1);
    flush();
    lasts = 0;
    checks += 2;
    if (obs_q.size() !== N) begin errors++; $display("[TB] FAIL hann_count: got %0d, expected %0d", obs_q.size(), N); end
    if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL hann_frame_cnt: got %0d, expected 1", frame_cnt); end
    if (obs_q.size() == N) begin
      checks += 2;
      if (obs_q[0].data !== 0) begin errors++; $display("[TB] FAIL hann_n0: got %0d, expected 0", obs_q[0].data); end
      if (obs_q[N-1].index !== N - 1 || obs_q[N-1].last !== 1'b1) begin
        errors++;
        $display("[TB] FAIL hann_end: got index %0d last %0b, expected %0d/1", obs_q[N-1].index, obs_q[N-1].last, N - 1);
      end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].last) lasts++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].index !== exp_q[i].index || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("[TB] FAIL hann_sample_%0d: got %0d/%0d/%0b, expected %0d/%0d/%0b", i,
                 obs_q[i].data, obs_q[i].index, obs_q[i].last, exp_q[i].data, exp_q[i].index, exp_q[i].last);
      end
    end
    checks++;
    if (lasts !== 1) begin errors++; $display("[TB] FAIL hann_last_count: got %0d, expected 1", lasts); end
  endtask

  task automatic test_stall();
    int d;
    int tries;
    bit acc;
    logic signed [DW-1:0] hd;
    logic [IW-1:0]        hi;
    logic                 hl;
    do_reset();
    win_sel = 2'd0;
    for (int k = 0; k < N; k++) begin
      d = int'($urandom_range(0, 255)) - 128;
      if (k == 20) begin
        hd = m_data; hi = m_index; hl = m_last;
        checks++;
        if (m_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_pre_valid: got %0b, expected 1", m_valid); end
        for (int c = 0; c < 5; c++) begin
          applyStimulus(1'b1, d, 1'b0, 1'b0, acc);
          checks++;
          if (acc || s_ready !== 1'b0 || m_valid !== 1'b1 || m_data !== hd || m_index !== hi || m_last !== hl) begin
            errors++;
            $display("[TB] FAIL stall_hold_%0d: got acc %0b s_ready %0b m %0b/%0d/%0d/%0b, expected 0 0 1/%0d/%0d/%0b",
                     c, acc, s_ready, m_valid, m_data, m_index, m_last, hd, hi, hl);
          end
        end
      end
      tries = 0;
      do begin
        applyStimulus(1'b1, d, k == N - 1, 1'b1, acc);
        tries++;
      end while (!acc && tries < 50);
    end
    flush();
    checks++;
    if (obs_q.size() !== N) begin errors++; $display("[TB] FAIL stall_count: got %0d, expected %0d", obs_q.size(), N); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].index !== exp_q[i].index || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("[TB] FAIL stall_sample_%0d: got %0d/%0d/%0b, expected %0d/%0d/%0b", i,
                 obs_q[i].data, obs_q[i].index, obs_q[i].last, exp_q[i].data, exp_q[i].index, exp_q[i].last);
      end
    end
  endtask

  task automatic test_early_last();
    do_reset();
    feed_frame(0, -1, 0, 41, 1'b1, 1'b0);
    feed_frame(0, -1, 0, 5, 1'b0, 1'b0);
    flush();
    checks += 3;
    if (frame_err !== 1'b1)  begin errors++; $display("[TB] FAIL early_err: got %0b, expected 1", frame_err); end
    if (frame_cnt !== 16'd1) begin errors++; $display("[TB] FAIL early_frame_cnt: got %0d, expected 1", frame_cnt); end
    if (obs_q.size() !== 46) begin errors++; $display("[TB] FAIL early_count: got %0d, expected 46", obs_q.size()); end
    if (obs_q.size() == 46) begin
      checks += 2;
      if (obs_q[40].index !== 40 || obs_q[40].last !== 1'b1) begin
        errors++; $display("[TB] FAIL early_last40: got %0d/%0b, expected 40/1", obs_q[40].index, obs_q[40].last);
      end
      if (obs_q[41].index !== 0) begin errors++; $display("[TB] FAIL early_restart: got %0d, expected 0", obs_q[41].index); end
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].index !== exp_q[i].index || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("[TB] FAIL early_sample_%0d: got %0d/%0d/%0b, expected %0d/%0d/%0b", i,
                 obs_q[i].data, obs_q[i].index, obs_q[i].last, exp_q[i].data, exp_q[i].index, exp_q[i].last);
      end
    end
    // Reset with samples still in flight, then restart the stream.
    feed_frame(0, -1, 0, 10, 1'b0, 1'b0);
    do_reset();
    checks += 3;
    if (frame_err !== 1'b0) begin errors++; $display("[TB] FAIL rst_clears_err: got %0b, expected 0", frame_err); end
    if (m_valid !== 1'b0)   begin errors++; $display("[TB] FAIL rst_discard: got %0b, expected 0", m_valid); end
    if (frame_cnt !== '0)   begin errors++; $display("[TB] FAIL rst_frame_cnt: got %0d, expected 0", frame_cnt); end
    feed_frame(1, -1, 0, 3, 1'b0, 1'b0);
    flush();
    checks++;
    if (obs_q.size() !== 3) begin errors++; $display("[TB] FAIL rst_count: got %0d, expected 3", obs_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].index !== exp_q[i].index) begin
        errors++;
        $display("[TB] FAIL rst_sample_%0d: got %0d/%0d, expected %0d/%0d", i,
                 obs_q[i].data, obs_q[i].index, exp_q[i].data, exp_q[i].index);
      end
    end
  endtask

  task automatic test_back_to_back();
    bit acc;
    int len;
    do_reset();
`ifdef WINDOW_COEF_WR_EN
    rand_writes = 1'b1;
`endif
    for (int b = 0; b < 6; b++) begin
      len = ($urandom_range(0, 2) == 0) ? int'($urandom_range(4, N - 1)) : N;
      feed_frame(int'($urandom_range(0, 3)), -1, 0, len, ($urandom_range(0, 1) == 1), 1'b1);
      repeat ($urandom_range(0, 3)) applyStimulus(1'b0, 0, 1'b0, ($urandom_range(0, 1) == 1), acc);
    end
    flush();
`ifdef WINDOW_COEF_WR_EN
    rand_writes = 1'b0;
    coef_we     = 1'b0;
`endif
    checks += 3;
    if (obs_q.size() !== exp_q.size()) begin
      errors++; $display("[TB] FAIL b2b_count: got %0d, expected %0d", obs_q.size(), exp_q.size());
    end
    if (frame_cnt !== FCW'(model_frames)) begin
      errors++; $display("[TB] FAIL b2b_frame_cnt: got %0d, expected %0d", frame_cnt, model_frames);
    end
    if (frame_err !== model_err) begin
      errors++; $display("[TB] FAIL b2b_frame_err: got %0b, expected %0b", frame_err, model_err);
    end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++;
      if (obs_q[i].data !== exp_q[i].data || obs_q[i].index !== exp_q[i].index || obs_q[i].last !== exp_q[i].last) begin
        errors++;
        $display("[TB] FAIL b2b_sample_%0d: got %0d/%0d/%0b, expected %0d/%0d/%0b", i,
                 obs_q[i].data, obs_q[i].index, obs_q[i].last, exp_q[i].data, exp_q[i].index, exp_q[i].last);
      end
    end
  endtask

`ifdef WINDOW_COEF_WR_EN
  task automatic test_user_table();
    bit acc;
    int hits;
    do_reset();
    coef_we    = 1'b1;
    coef_addr  = IW'(5);
    coef_wdata = CW'(128);
    applyStimulus(1'b0, 0, 1'b0, 1'b1, acc);
    coef_we = 1'b0;
    feed_frame(2, 5, -100, N, 1'b1, 1'b0);
    flush();
    hits = 0;
    for (int i = 0; i < obs_q.size(); i++) begin
      if (obs_q[i].index == 5 && hits == 0) begin
        hits++;
        checks++;
        if (obs_q[i].data !== -50) begin errors++; $display("[TB] FAIL user_n5: got %0d, expected -50", obs_q[i].data); end
      end
    end
    checks++;
    if (hits !== 1) begin errors++; $display("[TB] FAIL user_hits: got %0d, expected 1", hits); end
  endtask
`endif

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_latency();
    test_hamming_peak();
    test_hann_frame();
    test_stall();
    test_early_last();
`ifdef WINDOW_COEF_WR_EN
    test_user_table();
`endif
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
